hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  pipeline clock
- CpuRst  in  1  synchronous active-high reset
- ICacheMiss, DCacheMiss  in  1 each  cache miss in progress (level)
- BranchE, JalrE, JalD  in  1 each  taken branch / jalr in EX; jal in ID
- Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  5 each  register indices
- RegReadD, RegReadE  in  2 each  bit1 = rs1 used, bit0 = rs2 used
- MemToRegE  in  1  load in EX
- RegWriteM, RegWriteW  in  3 each  nonzero = stage writes rd
- StallF/D/E/M/W  out  1 each  driven to segment-register en as ~Stall
- FlushF/D/E/M/W  out  1 each  driven to segment-register clear
- Forward1E, Forward2E  out  2 each  00 = regfile, 10 = MEM, 01 = WB
- StallCycles, FlushEvents  out  32 each  performance counters
- MissTimeout  out  1  sticky miss-watchdog flag

Function
REQ-003 Stall and Flush outputs SHALL be combinational, evaluated in priority order REQ-004..REQ-008; any signal not asserted by the winning rule SHALL be 0.
REQ-004 CpuRst=1: all Flush* = 1, all Stall* = 0.
REQ-005 ICacheMiss|DCacheMiss = 1: all Stall* = 1, all Flush* = 0; redirects and load-use are ignored this cycle.
REQ-006 BranchE|JalrE = 1: FlushD = FlushE = 1; load-use stall suppressed.
REQ-007 Load-use SHALL be MemToRegE, RdE != 0, and (RdE==Rs1D with RegReadD[1], or RdE==Rs2D with RegReadD[0]).
- On load-use: StallF = StallD = 1, FlushE = 1.
- JalD flush is suppressed.
REQ-008 JalD = 1 alone: FlushD = 1.
REQ-009 Forward1E SHALL be:
- 10 if RegReadE[1], RegWriteM != 0, RdM != 0 and RdM == Rs1E;
- else 01 if the same conditions hold for RdW/RegWriteW;
- else 00.
Forward2E SHALL use RegReadE[0] and Rs2E the same way. MEM SHALL take priority over WB. Forwarding outputs are independent of reset and stall.
REQ-010 FSM states SHALL be RUN and MISS.
- RUN -> MISS on the first clock edge with a miss asserted.
- MISS -> RUN on the first edge with no miss.
- CpuRst SHALL force RUN from either state.
REQ-011 The internal 11-bit MissCnt SHALL load 1 on RUN->MISS, increment each cycle it stays in MISS, saturate at 1024, and clear on MISS->RUN.
REQ-012 MissTimeout SHALL set on the edge where MissCnt reaches 1024 and stay set until CpuRst.
REQ-013 StallCycles SHALL increment by 1 on every edge where StallF = 1 and CpuRst = 0; it wraps modulo 2^32.
REQ-014 FlushEvents SHALL increment by 1 on every edge where FlushD = 1 because of REQ-006 or REQ-008; it wraps modulo 2^32. Load-use and reset flushes SHALL NOT count.
REQ-015 A miss that rises in the same cycle as BranchE SHALL stall. The redirect SHALL then apply in the first cycle after the miss clears, because EX is held and BranchE persists. No redirect SHALL be lost or duplicated.

Reset
REQ-016 On the edge with CpuRst = 1, the state SHALL go to RUN and MissCnt, StallCycles, FlushEvents and MissTimeout SHALL go to 0.
REQ-017 CpuRst asserted mid-miss SHALL abort the miss count. The next cycle SHALL follow REQ-005 if the miss input is still high.

Verification
REQ-018 Load-use: MemToRegE=1, RdE=5, Rs1D=5, RegReadD=10 -> StallF=StallD=FlushE=1, FlushD=0; StallCycles +1 per cycle.
REQ-019 Branch during load-use: the REQ-018 stimulus plus BranchE=1 -> FlushD=FlushE=1, StallF=StallD=0; FlushEvents +1.
REQ-020 DCacheMiss held 3 cycles, with BranchE=1 from the first cycle -> all Stall*=1, no flush for 3 cycles. Cycle 4: FlushD=FlushE=1. StallCycles +3, FlushEvents +1.
REQ-021 Forwarding: Rs1E=7, RegReadE=11, RdM=7, RegWriteM=3'b010, RdW=7, RegWriteW=3'b010 -> Forward1E=10. Then RdM=0 -> Forward1E=01. With Rs2E=0 -> Forward2E=00.
REQ-022 Watchdog: ICacheMiss held 1030 cycles -> MissTimeout rises on cycle 1024 and stays 1 after the miss drops. CpuRst pulse -> MissTimeout=0 and counters=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: combinational stall/flush/forward decisions, plus a miss-watchdog FSM and perf counters.
// Stall/flush/forward outputs have zero latency; counters and MissTimeout update on the following clock edge.
module hazard_ctrl (
    input  logic        clk,
    input  logic        CpuRst,
    input  logic        ICacheMiss,
    input  logic        DCacheMiss,
    input  logic        BranchE,
    input  logic        JalrE,
    input  logic        JalD,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic [1:0]  RegReadD,
    input  logic [1:0]  RegReadE,
    input  logic        MemToRegE,
    input  logic [2:0]  RegWriteM,
    input  logic [2:0]  RegWriteW,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        StallW,
    output logic        FlushF,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        FlushW,
    output logic [1:0]  Forward1E,
    output logic [1:0]  Forward2E,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushEvents,
    output logic        MissTimeout
);

    localparam logic [10:0] MISS_SAT = 11'd1024;

    typedef enum logic {RUN, MISS} state_t;

    state_t      state_q, state_d;
    logic [10:0] miss_cnt_q, miss_cnt_d;
    logic        timeout_q, timeout_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    logic miss;
    logic redirect;
    logic load_use;
    logic count_flush;

    assign miss     = ICacheMiss | DCacheMiss;
    assign redirect = BranchE | JalrE;
    assign load_use = MemToRegE && (RdE != 5'd0) &&
                      (((RdE == Rs1D) && RegReadD[1]) || ((RdE == Rs2D) && RegReadD[0]));

    // Priority chain: reset > miss > redirect > load-use > jal.
    always_comb begin
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        StallW      = 1'b0;
        FlushF      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushM      = 1'b0;
        FlushW      = 1'b0;
        count_flush = 1'b0;
        if (CpuRst) begin
            FlushF = 1'b1;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
            FlushW = 1'b1;
        end else if (miss) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            StallW = 1'b1;
        end else if (redirect) begin
            FlushD      = 1'b1;
            FlushE      = 1'b1;
            count_flush = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (JalD) begin
            FlushD      = 1'b1;
            count_flush = 1'b1;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic       used,
                                           input logic [4:0] rs,
                                           input logic [4:0] rd_m,
                                           input logic [2:0] we_m,
                                           input logic [4:0] rd_w,
                                           input logic [2:0] we_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (used && (we_m != 3'd0) && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (used && (we_w != 3'd0) && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign Forward1E = fwd_sel(RegReadE[1], Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign Forward2E = fwd_sel(RegReadE[0], Rs2E, RdM, RegWriteM, RdW, RegWriteW);

    always_comb begin
        state_d    = state_q;
        miss_cnt_d = miss_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            RUN: begin
                if (miss) begin
                    state_d    = MISS;
                    miss_cnt_d = 11'd1;
                end
            end
            MISS: begin
                if (!miss) begin
                    state_d    = RUN;
                    miss_cnt_d = 11'd0;
                end else if (miss_cnt_q != MISS_SAT) begin
                    miss_cnt_d = miss_cnt_q + 11'd1;
                end
            end
            default: begin
                state_d    = RUN;
                miss_cnt_d = 11'd0;
            end
        endcase
        // Sticky until reset once the count reaches saturation.
        if (miss_cnt_d == MISS_SAT) begin
            timeout_d = 1'b1;
        end
    end

    assign stall_cycles_d = stall_cycles_q + {31'd0, StallF};
    assign flush_events_d = flush_events_q + {31'd0, count_flush};

    always_ff @(posedge clk) begin
        if (CpuRst) begin
            state_q        <= RUN;
            miss_cnt_q     <= 11'd0;
            timeout_q      <= 1'b0;
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            miss_cnt_q     <= miss_cnt_d;
            timeout_q      <= timeout_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign StallCycles = stall_cycles_q;
    assign FlushEvents = flush_events_q;
    assign MissTimeout = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, hand sequences for multi-cycle cases, and random stimulus vs a rule-level model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        CpuRst, ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, MemToRegE;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  RegReadD, RegReadE;
    logic [2:0]  RegWriteM, RegWriteW;
    logic        StallF, StallD, StallE, StallM, StallW;
    logic        FlushF, FlushD, FlushE, FlushM, FlushW;
    logic [1:0]  Forward1E, Forward2E;
    logic [31:0] StallCycles, FlushEvents;
    logic        MissTimeout;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .CpuRst(CpuRst), .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
        .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegReadD(RegReadD), .RegReadE(RegReadE), .MemToRegE(MemToRegE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushF(FlushF), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .Forward1E(Forward1E), .Forward2E(Forward2E),
        .StallCycles(StallCycles), .FlushEvents(FlushEvents), .MissTimeout(MissTimeout)
    );

    typedef struct packed {
        logic       rst, imiss, dmiss, br, jalr, jald, m2r;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rrd, rre;
        logic [2:0] rwm, rww;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [4:0] st;
        logic [4:0] fl;
        logic [1:0] f1, f2;
    } vec_t;

    typedef struct packed {
        logic [4:0] st;
        logic [4:0] fl;
        logic [1:0] f1, f2;
        logic [2:0] rule;
    } out_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: counters plus length of the current unbroken miss run.
    logic [31:0] m_stall, m_flush;
    int          m_run;
    logic        m_to;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic in_t zin();
        in_t x;
        x = '0;
        return x;
    endfunction

    function automatic in_t lu_in();
        in_t x;
        x = '0;
        x.m2r = 1'b1; x.rde = 5'd5; x.rs1d = 5'd5; x.rrd = 2'b10;
        return x;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic used, input logic [4:0] rs, input in_t x);
        if (used && x.rwm != 0 && x.rdm != 0 && x.rdm == rs) return 2'b10;
        if (used && x.rww != 0 && x.rdw != 0 && x.rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    // rule: 1 reset, 2 miss, 3 redirect, 4 load-use, 5 jal, 0 none
    function automatic out_t model_comb(input in_t x);
        out_t o;
        logic lu;
        o  = '0;
        lu = x.m2r && x.rde != 0 &&
             ((x.rde == x.rs1d && x.rrd[1]) || (x.rde == x.rs2d && x.rrd[0]));
        if (x.rst)                 o.rule = 3'd1;
        else if (x.imiss | x.dmiss) o.rule = 3'd2;
        else if (x.br | x.jalr)    o.rule = 3'd3;
        else if (lu)               o.rule = 3'd4;
        else if (x.jald)           o.rule = 3'd5;
        case (o.rule)
            3'd1: o.fl = 5'b11111;
            3'd2: o.st = 5'b11111;
            3'd3: o.fl = 5'b01100;
            3'd4: begin o.st = 5'b11000; o.fl = 5'b00100; end
            3'd5: o.fl = 5'b01000;
            default: ;
        endcase
        o.f1 = ref_fwd(x.rre[1], x.rs1e, x);
        o.f2 = ref_fwd(x.rre[0], x.rs2e, x);
        return o;
    endfunction

    function automatic logic [4:0] dut_st();
        return {StallF, StallD, StallE, StallM, StallW};
    endfunction

    function automatic logic [4:0] dut_fl();
        return {FlushF, FlushD, FlushE, FlushM, FlushW};
    endfunction

    task automatic drive(input in_t x);
        CpuRst = x.rst; ICacheMiss = x.imiss; DCacheMiss = x.dmiss;
        BranchE = x.br; JalrE = x.jalr; JalD = x.jald; MemToRegE = x.m2r;
        Rs1D = x.rs1d; Rs2D = x.rs2d; Rs1E = x.rs1e; Rs2E = x.rs2e;
        RdE = x.rde; RdM = x.rdm; RdW = x.rdw;
        RegReadD = x.rrd; RegReadE = x.rre; RegWriteM = x.rwm; RegWriteW = x.rww;
        #2;
    endtask

    task automatic check_model(input in_t x, input string tag);
        out_t o;
        o = model_comb(x);
        chk({tag, " stall"}, {27'd0, dut_st()}, {27'd0, o.st});
        chk({tag, " flush"}, {27'd0, dut_fl()}, {27'd0, o.fl});
        chk({tag, " fwd1"}, {30'd0, Forward1E}, {30'd0, o.f1});
        chk({tag, " fwd2"}, {30'd0, Forward2E}, {30'd0, o.f2});
        chk({tag, " StallCycles"}, StallCycles, m_stall);
        chk({tag, " FlushEvents"}, FlushEvents, m_flush);
        chk({tag, " MissTimeout"}, {31'd0, MissTimeout}, {31'd0, m_to});
    endtask

    task automatic edge_update(input in_t x);
        out_t o;
        @(posedge clk);
        o = model_comb(x);
        if (x.rst) begin
            m_stall = 0; m_flush = 0; m_run = 0; m_to = 1'b0;
        end else begin
            if (o.st[4]) m_stall = m_stall + 1;
            if (o.rule == 3'd3 || o.rule == 3'd5) m_flush = m_flush + 1;
            if (x.imiss | x.dmiss) begin
                m_run++;
                if (m_run >= 1024) m_to = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    task automatic step(input in_t x, input string tag);
        drive(x);
        check_model(x, tag);
        edge_update(x);
    endtask

    function automatic in_t rnd_in();
        in_t x;
        x.rst   = ($urandom % 40) == 0;
        x.imiss = ($urandom % 10) == 0;
        x.dmiss = ($urandom % 10) == 0;
        x.br    = ($urandom % 6) == 0;
        x.jalr  = ($urandom % 8) == 0;
        x.jald  = ($urandom % 5) == 0;
        x.m2r   = ($urandom % 3) == 0;
        x.rs1d  = 5'($urandom % 4); x.rs2d = 5'($urandom % 4);
        x.rs1e  = 5'($urandom % 4); x.rs2e = 5'($urandom % 4);
        x.rde   = 5'($urandom % 4); x.rdm  = 5'($urandom % 4); x.rdw = 5'($urandom % 4);
        x.rrd   = 2'($urandom);     x.rre  = 2'($urandom);
        x.rwm   = (($urandom % 3) == 0) ? 3'd0 : 3'($urandom);
        x.rww   = (($urandom % 3) == 0) ? 3'd0 : 3'($urandom);
        return x;
    endfunction

    in_t r, z;

    initial begin
        m_stall = 0; m_flush = 0; m_run = 0; m_to = 1'b0;
        z = zin();

        r = zin();                                  tbl[0]  = '{r, 5'b00000, 5'b00000, 2'b00, 2'b00};
        r = zin(); r.rst = 1;                       tbl[1]  = '{r, 5'b00000, 5'b11111, 2'b00, 2'b00};
        r = zin(); r.imiss = 1;                     tbl[2]  = '{r, 5'b11111, 5'b00000, 2'b00, 2'b00};
        r = lu_in(); r.dmiss = 1; r.br = 1;         tbl[3]  = '{r, 5'b11111, 5'b00000, 2'b00, 2'b00};
        r = lu_in();                                tbl[4]  = '{r, 5'b11000, 5'b00100, 2'b00, 2'b00};
        r = lu_in(); r.br = 1;                      tbl[5]  = '{r, 5'b00000, 5'b01100, 2'b00, 2'b00};
        r = zin(); r.jald = 1;                      tbl[6]  = '{r, 5'b00000, 5'b01000, 2'b00, 2'b00};
        r = lu_in(); r.jald = 1;                    tbl[7]  = '{r, 5'b11000, 5'b00100, 2'b00, 2'b00};
        r = zin(); r.m2r = 1; r.rde = 6; r.rs2d = 6; r.rrd = 2'b01;
                                                    tbl[8]  = '{r, 5'b11000, 5'b00100, 2'b00, 2'b00};
        r = zin(); r.m2r = 1; r.rrd = 2'b11;        tbl[9]  = '{r, 5'b00000, 5'b00000, 2'b00, 2'b00};
        r = lu_in(); r.rrd = 2'b01;                 tbl[10] = '{r, 5'b00000, 5'b00000, 2'b00, 2'b00};
        r = zin(); r.jalr = 1;                      tbl[11] = '{r, 5'b00000, 5'b01100, 2'b00, 2'b00};
        r = zin(); r.rst = 1; r.imiss = 1; r.br = 1; tbl[12] = '{r, 5'b00000, 5'b11111, 2'b00, 2'b00};
        r = zin(); r.rs1e = 7; r.rre = 2'b11; r.rdm = 7; r.rwm = 3'b010; r.rdw = 7; r.rww = 3'b010;
                                                    tbl[13] = '{r, 5'b00000, 5'b00000, 2'b10, 2'b00};
        r.rdm = 0;                                  tbl[14] = '{r, 5'b00000, 5'b00000, 2'b01, 2'b00};
        r = zin(); r.rs2e = 9; r.rdw = 9; r.rww = 3'b100; r.rdm = 9; r.rre = 2'b01;
                                                    tbl[15] = '{r, 5'b00000, 5'b00000, 2'b00, 2'b01};
        r = zin(); r.rs1e = 3; r.rs2e = 3; r.rdm = 3; r.rwm = 3'd1; r.rre = 2'b10;
                                                    tbl[16] = '{r, 5'b00000, 5'b00000, 2'b10, 2'b00};
        r = zin(); r.rst = 1; r.rs1e = 4; r.rdm = 4; r.rwm = 3'd7; r.rre = 2'b10;
                                                    tbl[17] = '{r, 5'b00000, 5'b11111, 2'b10, 2'b00};

        r = zin(); r.rst = 1;
        step(r, "init");
        chk("reset StallCycles", StallCycles, 32'd0);
        chk("reset FlushEvents", FlushEvents, 32'd0);
        chk("reset MissTimeout", {31'd0, MissTimeout}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].in);
            chk($sformatf("vec%0d stall", i), {27'd0, dut_st()}, {27'd0, tbl[i].st});
            chk($sformatf("vec%0d flush", i), {27'd0, dut_fl()}, {27'd0, tbl[i].fl});
            chk($sformatf("vec%0d fwd1", i), {30'd0, Forward1E}, {30'd0, tbl[i].f1});
            chk($sformatf("vec%0d fwd2", i), {30'd0, Forward2E}, {30'd0, tbl[i].f2});
            check_model(tbl[i].in, $sformatf("vec%0d model", i));
            edge_update(tbl[i].in);
        end

        // Load-use held 3 cycles, then a branch during load-use.
        r = zin(); r.rst = 1; step(r, "lu rst");
        for (int i = 0; i < 3; i++) step(lu_in(), "lu");
        chk("lu StallCycles", StallCycles, 32'd3);
        chk("lu FlushEvents", FlushEvents, 32'd0);
        r = lu_in(); r.br = 1; step(r, "lu+br");
        chk("lu+br FlushEvents", FlushEvents, 32'd1);
        chk("lu+br StallCycles", StallCycles, 32'd3);

        // Miss rising together with a branch: redirect is held, then applied once.
        r = zin(); r.rst = 1; step(r, "mb rst");
        r = zin(); r.dmiss = 1; r.br = 1;
        for (int i = 0; i < 3; i++) begin
            drive(r);
            chk($sformatf("mb%0d stall", i), {27'd0, dut_st()}, 32'h1f);
            chk($sformatf("mb%0d flush", i), {27'd0, dut_fl()}, 32'h00);
            edge_update(r);
        end
        r.dmiss = 0;
        drive(r);
        chk("mb3 flush", {27'd0, dut_fl()}, 32'h0c);
        chk("mb3 stall", {27'd0, dut_st()}, 32'h00);
        edge_update(r);
        chk("mb StallCycles", StallCycles, 32'd3);
        chk("mb FlushEvents", FlushEvents, 32'd1);

        // Reset in the middle of a miss; miss still high afterwards.
        r = zin(); r.imiss = 1;
        for (int i = 0; i < 4; i++) step(r, "rmiss");
        r.rst = 1; step(r, "rmiss rst");
        r.rst = 0;
        for (int i = 0; i < 3; i++) step(r, "rmiss post");
        step(z, "rmiss end");

        // Watchdog.
        r = zin(); r.rst = 1; step(r, "wd rst");
        r = zin(); r.imiss = 1;
        for (int i = 1; i <= 1030; i++) begin
            drive(r);
            check_model(r, "wd");
            if (i == 1024) chk("wd before 1024", {31'd0, MissTimeout}, 32'd0);
            edge_update(r);
            if (i == 1024) chk("wd at 1024", {31'd0, MissTimeout}, 32'd1);
        end
        step(z, "wd drop");
        chk("wd sticky", {31'd0, MissTimeout}, 32'd1);
        chk("wd StallCycles", StallCycles, 32'd1030);
        r = zin(); r.rst = 1; step(r, "wd clr");
        chk("wd clr MissTimeout", {31'd0, MissTimeout}, 32'd0);
        chk("wd clr StallCycles", StallCycles, 32'd0);
        chk("wd clr FlushEvents", FlushEvents, 32'd0);

        for (int i = 0; i < 500; i++) begin
            r = rnd_in();
            step(r, $sformatf("rnd%0d", i));
        end
        drive(z);
        check_model(z, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
